lcd_bus_arbiter: RTL
====================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 2: cycles that RS/DB are held valid before EN rises.
REQ-002 The block SHALL have parameter EN_CYC, default 12: cycles that EN is held high.
REQ-003 The block SHALL have parameter HOLD_CYC, default 2: cycles that RS/DB are held after EN falls.
REQ-004 The block SHALL have parameter WAIT_CMD_CYC, default 2000: settle cycles after a normal write.
REQ-005 The block SHALL have parameter WAIT_CLR_CYC, default 82000: settle cycles after a clear (0x01) or home (0x02) command.
REQ-006 The block SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports req0 / req1, input, 1 bit each: the write request from requester 0 (Nios) and requester 1 (score hardware).
REQ-009 The block SHALL have ports rs0 / rs1, input, 1 bit each: the requested RS value (0 = command, 1 = data).
REQ-010 The block SHALL have ports db0 / db1, input, 8 bits each: the requested byte.
REQ-011 The block SHALL have ports ack0 / ack1, output, 1 bit each: a one-cycle pulse marking request accepted and operands latched.
REQ-012 The block SHALL have ports done0 / done1, output, 1 bit each: a one-cycle pulse marking the transaction complete.
REQ-013 The block SHALL have ports lcd_out_rs, lcd_out_rw, lcd_out_en, output, 1 bit each, and lcd_out_db, output, 8 bits: the HD44780 bus.
REQ-014 The block SHALL have port busy_export, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-016 In IDLE with either req sampled high at an edge, the FSM SHALL take the grant, latch that requester's rs/db, and enter SETUP.
REQ-017 The granted ack SHALL be high during the first SETUP cycle only.
REQ-018 With ack in cycle t: lcd_out_en SHALL be high in cycles t+SETUP_CYC .. t+SETUP_CYC+EN_CYC-1.
REQ-019 HOLD SHALL follow EN_HI for HOLD_CYC cycles, then WAIT SHALL last for the selected wait count.
REQ-020 The granted done SHALL pulse in the first IDLE cycle after WAIT; with defaults, done comes at t+2016.
REQ-021 The long wait (WAIT_CLR_CYC) SHALL apply only when the latched rs=0 and db is 0x01 or 0x02; every other write SHALL use WAIT_CMD_CYC.
REQ-022 lcd_out_rs and lcd_out_db SHALL be stable from the first SETUP cycle through the last HOLD cycle, and SHALL keep their last values in WAIT and IDLE.
REQ-023 lcd_out_rw SHALL be constant 0 (write-only bus).
REQ-024 Requester inputs SHALL be ignored outside IDLE; a requester may drop req after its ack, and a req still high after done SHALL be treated as a new request.
REQ-025 A new grant SHALL be taken in the same IDLE cycle in which done pulses (back-to-back operation).
REQ-026 At most one ack and at most one done SHALL be high in any cycle.
REQ-027 All down-counters SHALL be sized for the largest parameter, and all parameters SHALL be at least 1.

Reset
REQ-028 On reset, the block SHALL force IDLE and drive lcd_out_rs=0, lcd_out_rw=0, lcd_out_en=0, lcd_out_db=0x00, busy_export=0, and all ack/done = 0.
REQ-029 A reset during any state SHALL abort the transaction at that edge: EN low in the next cycle, no done issued for the aborted transaction.
REQ-030 On reset, the round-robin pointer SHALL be set so that requester 0 wins the first tie.

Configuration
REQ-031 With LCD_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins, and the pointer updates on each ack.
REQ-032 Without LCD_ARB_RR_EN, requester 0 SHALL always win a tie, and no pointer register SHALL exist.

Verification
REQ-033 Reset, then req0=1, rs0=1, db0=0x41 -> ack0 in cycle t, EN high t+2..t+13, DB=0x41 and RS=1 t..t+15, done0 at t+2016, busy high t..t+2015.
REQ-034 req1=1, rs1=0, db1=0x01 -> done1 at t+82016; a second req1 with db1=0x80 -> done at t+2016.
REQ-035 req0 and req1 both held high with LCD_ARB_RR_EN -> acks alternate 0,1,0,1; without the macro -> ack0 only, while req1 is starved.
REQ-036 reset_reset pulsed at t+5 of a write -> EN low at t+6, busy 0, no done0, all outputs at reset values.
REQ-037 req1 held high, with req0 raised at t+100 mid-transaction -> req0 ignored until IDLE, then granted on the done cycle (t+2016) under round-robin.

Source files
------------

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake bundle for the LCD bus arbiter.
// Two requesters (0 = Nios, 1 = score hardware) share one HD44780 bus.
interface lcd_bus_arbiter_if;
   logic       req0;
   logic       req1;
   logic       rs0;
   logic       rs1;
   logic [7:0] db0;
   logic [7:0] db1;
   logic       ack0;
   logic       ack1;
   logic       done0;
   logic       done1;

   modport master (
      output req0, req1, rs0, rs1, db0, db1,
      input  ack0, ack1, done0, done1
   );

   modport slave (
      input  req0, req1, rs0, rs1, db0, db1,
      output ack0, ack1, done0, done1
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester HD44780 write arbiter with setup/enable/hold/settle timing.
// Define LCD_ARB_RR_EN for round-robin tie breaking (default: requester 0 wins).
module lcd_bus_arbiter #(
   parameter int SETUP_CYC    = 2,
   parameter int EN_CYC       = 12,
   parameter int HOLD_CYC     = 2,
   parameter int WAIT_CMD_CYC = 2000,
   parameter int WAIT_CLR_CYC = 82000
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   lcd_bus_arbiter_if.slave req_if,
   output logic             lcd_out_rs,
   output logic             lcd_out_rw,
   output logic             lcd_out_en,
   output logic [7:0]       lcd_out_db,
   output logic             busy_export
);

   localparam int M1 = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int M2 = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
   localparam int M3 = (M2 > WAIT_CMD_CYC) ? M2 : WAIT_CMD_CYC;
   localparam int MX = (M3 > WAIT_CLR_CYC) ? M3 : WAIT_CLR_CYC;
   localparam int CW = $clog2(MX + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      HOLD,
      WAIT
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_ld;
   logic          sel_q;
   logic          rs_q;
   logic [7:0]    db_q;
   logic          done_q;
   logic          any_req;
   logic          pick;
   logic          cnt_zero;
   logic          long_wait;

   assign any_req   = req_if.req0 | req_if.req1;
   assign cnt_zero  = (cnt_q == '0);
   assign long_wait = ~rs_q & ((db_q == 8'h01) | (db_q == 8'h02));

`ifdef LCD_ARB_RR_EN
   logic last_q;

   // On a tie the requester not granted last wins.
   assign pick = req_if.req1 & (~req_if.req0 | ~last_q);

   always_ff @(posedge clk_clk) begin
      if (reset_reset)
         last_q <= 1'b1;
      else if (state_q == IDLE && any_req)
         last_q <= pick;
   end
`else
   assign pick = req_if.req1 & ~req_if.req0;
`endif

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         rs_q    <= 1'b0;
         db_q    <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == WAIT) && cnt_zero;
         if (state_q != state_d)
            cnt_q <= cnt_ld;
         else if (!cnt_zero)
            cnt_q <= cnt_q - 1'b1;
         if (state_q == IDLE && any_req) begin
            sel_q <= pick;
            rs_q  <= pick ? req_if.rs1 : req_if.rs0;
            db_q  <= pick ? req_if.db1 : req_if.db0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_ld  = '0;
      unique case (state_q)
         IDLE:  if (any_req) state_d = SETUP;
         SETUP: if (cnt_zero) state_d = EN_HI;
         EN_HI: if (cnt_zero) state_d = HOLD;
         HOLD:  if (cnt_zero) state_d = WAIT;
         WAIT:  if (cnt_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      unique case (state_d)
         SETUP:   cnt_ld = CW'(SETUP_CYC - 1);
         EN_HI:   cnt_ld = CW'(EN_CYC - 1);
         HOLD:    cnt_ld = CW'(HOLD_CYC - 1);
         WAIT:    cnt_ld = long_wait ? CW'(WAIT_CLR_CYC - 1)
                                     : CW'(WAIT_CMD_CYC - 1);
         default: cnt_ld = '0;
      endcase
   end

   logic first_setup;

   always_comb begin
      first_setup  = (state_q == SETUP) && (cnt_q == CW'(SETUP_CYC - 1));
      req_if.ack0  = first_setup & ~sel_q;
      req_if.ack1  = first_setup & sel_q;
      req_if.done0 = done_q & ~sel_q;
      req_if.done1 = done_q & sel_q;
      lcd_out_en   = (state_q == EN_HI);
      busy_export  = (state_q != IDLE);
      lcd_out_rs   = rs_q;
      lcd_out_db   = db_q;
      lcd_out_rw   = 1'b0;
   end

endmodule
